// File: rtl/mult_sched.sv
// -----------------------------------------------------------------------------
// mult_sched -- round-robin scheduler sharing one fixed-point multiplier
//
// NUM_CH channels each offer an A and a B operand FIFO plus a result FIFO.
// In IDLE the scheduler grants the first eligible channel at or after rr_ptr.
// It pops both operand heads in the same cycle and latches the dequantized
// product. In WRITE it pushes that product into the granted channel's result
// FIFO. While the result FIFO is full, WRITE is held.
//
// Optional feature macro: MULT_SCHED_SKIP_FULL_EN
//   defined   -> a channel whose result FIFO is full is not eligible for grant
//   undefined -> out_full is ignored at grant time (head-of-line blocking)
//
// Parameters
//   DATA_WIDTH : sample width, signed two's complement fixed point
//   BITS       : fractional bits removed after the multiply
//   NUM_CH     : number of channels (2..4)
//
// Ports (channel c uses slice [c*DATA_WIDTH +: DATA_WIDTH] / bit c)
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   a_dout, a_empty   : A FIFO heads and empty flags
//   a_rd_en           : A FIFO pop strobes (combinational)
//   b_dout, b_empty   : B FIFO heads and empty flags
//   b_rd_en           : B FIFO pop strobes (combinational)
//   out_din           : shared result data (held between writes)
//   out_full          : result FIFO full flags
//   out_wr_en         : result FIFO write strobes (combinational)
//   busy              : high while a result waits in WRITE
//   grant_ch          : channel currently held, or the last channel granted
// -----------------------------------------------------------------------------
module mult_sched #(
    parameter int DATA_WIDTH = 16,
    parameter int BITS       = 10,
    parameter int NUM_CH     = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   a_dout,
    input  logic [NUM_CH-1:0]              a_empty,
    output logic [NUM_CH-1:0]              a_rd_en,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   b_dout,
    input  logic [NUM_CH-1:0]              b_empty,
    output logic [NUM_CH-1:0]              b_rd_en,
    output logic [DATA_WIDTH-1:0]          out_din,
    input  logic [NUM_CH-1:0]              out_full,
    output logic [NUM_CH-1:0]              out_wr_en,
    output logic                           busy,
    output logic [$clog2(NUM_CH)-1:0]      grant_ch
);

    localparam int CW = $clog2(NUM_CH);

    // One-hot encoding leaves illegal codes that recover to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b01,
        ST_WRITE = 2'b10
    } state_t;

    state_t                   state_q,  state_d;
    logic [CW-1:0]            rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]            cur_ch_q, cur_ch_d;
    logic [DATA_WIDTH-1:0]    result_q, result_d;

    logic [NUM_CH-1:0]        elig_s;
    logic                     found_s;
    logic [CW-1:0]            sel_s;
    logic signed [DATA_WIDTH-1:0]   a_sel_s;
    logic signed [DATA_WIDTH-1:0]   b_sel_s;
    logic signed [2*DATA_WIDTH-1:0] prod_s;
    logic [NUM_CH-1:0]        a_rd_s;
    logic [NUM_CH-1:0]        b_rd_s;
    logic [NUM_CH-1:0]        wr_s;

    // (base + off) mod NUM_CH for off < NUM_CH; works for non-power-of-two NUM_CH.
    function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_CH) begin
            sum = sum - NUM_CH;
        end else begin
            sum = sum;
        end
        return CW'(sum);
    endfunction

    // Channel after c, wrapping at NUM_CH.
    function automatic logic [CW-1:0] next_ch(input logic [CW-1:0] c);
        logic [CW-1:0] n;
        if (int'(c) == NUM_CH - 1) begin
            n = {CW{1'b0}};
        end else begin
            n = c + {{(CW-1){1'b0}}, 1'b1};
        end
        return n;
    endfunction

    // Dequantize: adding 2^BITS-1 before the arithmetic shift of a negative
    // product turns floor into round-toward-zero. Low bits are kept (wrap).
    function automatic logic [DATA_WIDTH-1:0] deq(input logic signed [2*DATA_WIDTH-1:0] p);
        logic signed [2*DATA_WIDTH-1:0] rnd;
        logic signed [2*DATA_WIDTH-1:0] shifted;
        rnd = {{(2*DATA_WIDTH-BITS){1'b0}}, {BITS{1'b1}}};
        if (p[2*DATA_WIDTH-1]) begin
            shifted = (p + rnd) >>> BITS;
        end else begin
            shifted = p >>> BITS;
        end
        return shifted[DATA_WIDTH-1:0];
    endfunction

`ifdef MULT_SCHED_SKIP_FULL_EN
    // A full result FIFO takes its channel out of arbitration.
    assign elig_s = ~a_empty & ~b_empty & ~out_full;
`else
    // Full result FIFOs are handled in WRITE by stalling.
    assign elig_s = ~a_empty & ~b_empty;
`endif

    // Round-robin search starting at rr_ptr; first eligible channel wins.
    always_comb begin
        found_s = 1'b0;
        sel_s   = {CW{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found_s && elig_s[rr_idx(rr_ptr_q, i)]) begin
                found_s = 1'b1;
                sel_s   = rr_idx(rr_ptr_q, i);
            end else begin
                found_s = found_s;
            end
        end
    end

    assign a_sel_s = a_dout[int'(sel_s)*DATA_WIDTH +: DATA_WIDTH];
    assign b_sel_s = b_dout[int'(sel_s)*DATA_WIDTH +: DATA_WIDTH];
    assign prod_s  = a_sel_s * b_sel_s;

    // Next-state, datapath capture and raw strobe generation.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cur_ch_d = cur_ch_q;
        result_d = result_q;
        a_rd_s   = {NUM_CH{1'b0}};
        b_rd_s   = {NUM_CH{1'b0}};
        wr_s     = {NUM_CH{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    a_rd_s[sel_s] = 1'b1;
                    b_rd_s[sel_s] = 1'b1;
                    result_d      = deq(prod_s);
                    cur_ch_d      = sel_s;
                    state_d       = ST_WRITE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // Held result is never dropped: WRITE waits out a full FIFO.
                if (!out_full[cur_ch_q]) begin
                    wr_s[cur_ch_q] = 1'b1;
                    rr_ptr_d       = next_ch(cur_ch_q);
                    state_d        = ST_IDLE;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= {CW{1'b0}};
            cur_ch_q <= {CW{1'b0}};
            result_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cur_ch_q <= cur_ch_d;
            result_q <= result_d;
        end
    end

    // Reset suppresses strobes in the same cycle so nothing is popped or written.
    assign a_rd_en   = reset ? {NUM_CH{1'b0}} : a_rd_s;
    assign b_rd_en   = reset ? {NUM_CH{1'b0}} : b_rd_s;
    assign out_wr_en = reset ? {NUM_CH{1'b0}} : wr_s;
    assign out_din   = result_q;
    assign busy      = (state_q == ST_WRITE);
    assign grant_ch  = cur_ch_q;

endmodule

// File: tb/tb_mult_sched.sv
// -----------------------------------------------------------------------------
// tb_mult_sched -- self-checking bench for mult_sched
//
// A two-channel instance is fed from modelled operand FIFOs. Expected results
// are pushed per channel when operands are queued and popped when the DUT
// writes that channel. A four-channel instance checks rotation from rr_ptr=3.
// -----------------------------------------------------------------------------
module tb_mult_sched;

    localparam int DW = 16;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic            reset;
    logic [2*DW-1:0] a_dout, b_dout;
    logic [1:0]      a_empty, b_empty, a_rd_en, b_rd_en, out_full, out_wr_en;
    logic [DW-1:0]   out_din;
    logic            busy;
    logic [0:0]      grant_ch;

    logic [4*DW-1:0] a4_dout, b4_dout;
    logic [3:0]      a4_empty, b4_empty, a4_rd_en, b4_rd_en, out4_full, out4_wr_en;
    logic [DW-1:0]   out4_din;
    logic            busy4;
    logic [1:0]      grant4_ch;

    mult_sched #(.DATA_WIDTH(16), .BITS(10), .NUM_CH(2)) u_dut (
        .clock(clock), .reset(reset),
        .a_dout(a_dout), .a_empty(a_empty), .a_rd_en(a_rd_en),
        .b_dout(b_dout), .b_empty(b_empty), .b_rd_en(b_rd_en),
        .out_din(out_din), .out_full(out_full), .out_wr_en(out_wr_en),
        .busy(busy), .grant_ch(grant_ch)
    );

    mult_sched #(.DATA_WIDTH(16), .BITS(10), .NUM_CH(4)) u_dut4 (
        .clock(clock), .reset(reset),
        .a_dout(a4_dout), .a_empty(a4_empty), .a_rd_en(a4_rd_en),
        .b_dout(b4_dout), .b_empty(b4_empty), .b_rd_en(b4_rd_en),
        .out_din(out4_din), .out_full(out4_full), .out_wr_en(out4_wr_en),
        .busy(busy4), .grant_ch(grant4_ch)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [31:0] opq0[$], opq1[$];
    logic [15:0] eq0[$], eq1[$];
    int          grant_log[$];
    int          wr_cyc[$];

    logic [1:0]  obs_a_rd, obs_b_rd, obs_wr;
    logic [15:0] obs_din;
    logic        obs_busy;
    logic [0:0]  obs_grant;
    logic [3:0]  obs4_rd, obs4_wr;
    logic [15:0] obs4_din;

    // Reference: signed integer division truncates toward zero.
    function automatic logic [15:0] model_deq(input logic [15:0] a, input logic [15:0] b);
        longint p;
        longint q;
        p = longint'($signed(a)) * longint'($signed(b));
        q = p / 1024;
        return q[15:0];
    endfunction

    task automatic push(input int ch, input logic [15:0] a, input logic [15:0] b, input logic [15:0] e);
        if (ch == 0) begin
            opq0.push_back({a, b});
            eq0.push_back(e);
        end else begin
            opq1.push_back({a, b});
            eq1.push_back(e);
        end
    endtask

    task automatic push_m(input int ch, input logic [15:0] a, input logic [15:0] b);
        push(ch, a, b, model_deq(a, b));
    endtask

    task automatic drive_heads();
        if (opq0.size() != 0) begin
            a_dout[15:0] = opq0[0][31:16];
            b_dout[15:0] = opq0[0][15:0];
            a_empty[0] = 1'b0;
            b_empty[0] = 1'b0;
        end else begin
            a_empty[0] = 1'b1;
            b_empty[0] = 1'b1;
        end
        if (opq1.size() != 0) begin
            a_dout[31:16] = opq1[0][31:16];
            b_dout[31:16] = opq1[0][15:0];
            a_empty[1] = 1'b0;
            b_empty[1] = 1'b0;
        end else begin
            a_empty[1] = 1'b1;
            b_empty[1] = 1'b1;
        end
    endtask

    task automatic check_write(input int c);
        logic [15:0] e;
        wr_cyc.push_back(cycle);
        checks++;
        if ((c == 0 && eq0.size() == 0) || (c == 1 && eq1.size() == 0)) begin
            errors++;
            $display("FAIL unexpected_write ch=%0d din=%h, no result pending", c, obs_din);
        end else begin
            e = (c == 0) ? eq0.pop_front() : eq1.pop_front();
            if (obs_din !== e) begin
                errors++;
                $display("FAIL result ch=%0d got %h expected %h", c, obs_din, e);
            end
        end
        checks++;
        if (int'(obs_grant) != c) begin
            errors++;
            $display("FAIL grant_at_write got %0d expected %0d", obs_grant, c);
        end
    endtask

    // One cycle: drive FIFO heads at the falling edge, sample, model pops, advance.
    task automatic step();
        drive_heads();
        #1;
        obs_a_rd  = a_rd_en;
        obs_b_rd  = b_rd_en;
        obs_wr    = out_wr_en;
        obs_din   = out_din;
        obs_busy  = busy;
        obs_grant = grant_ch;
        obs4_rd   = a4_rd_en;
        obs4_wr   = out4_wr_en;
        obs4_din  = out4_din;
        checks++;
        if (($countones(obs_a_rd) > 1) || (obs_a_rd !== obs_b_rd) ||
            ($countones(obs_wr) > 1) || ((obs_a_rd != 2'b00) && (obs_wr != 2'b00))) begin
            errors++;
            $display("FAIL strobe_rules a_rd=%b b_rd=%b wr=%b need one-hot, a==b, rd/wr exclusive",
                     obs_a_rd, obs_b_rd, obs_wr);
        end
        if (obs_a_rd[0]) begin
            if (opq0.size() == 0) begin
                errors++;
                $display("FAIL pop_empty ch=0 rd=1 expected 0");
            end else begin
                void'(opq0.pop_front());
            end
            grant_log.push_back(0);
        end
        if (obs_a_rd[1]) begin
            if (opq1.size() == 0) begin
                errors++;
                $display("FAIL pop_empty ch=1 rd=1 expected 0");
            end else begin
                void'(opq1.pop_front());
            end
            grant_log.push_back(1);
        end
        if (obs_wr[0]) check_write(0);
        if (obs_wr[1]) check_write(1);
        cycle++;
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic bit drained();
        return (opq0.size() == 0) && (opq1.size() == 0) &&
               (eq0.size() == 0) && (eq1.size() == 0) && !obs_busy;
    endfunction

    task automatic run_drain(input int budget, input bit rand_full);
        int n;
        n = 0;
        while (!drained() && n < budget) begin
            if (rand_full) out_full = 2'($urandom_range(0, 3));
            else out_full = 2'b00;
            step();
            n++;
        end
        out_full = 2'b00;
        checks++;
        if (!drained()) begin
            errors++;
            $display("FAIL drain_timeout pending a0=%0d a1=%0d e0=%0d e1=%0d expected all 0",
                     opq0.size(), opq1.size(), eq0.size(), eq1.size());
        end
    endtask

    task automatic do_reset();
        opq0.delete(); opq1.delete(); eq0.delete(); eq1.delete();
        out_full  = 2'b00;
        a4_empty  = 4'hF;
        b4_empty  = 4'hF;
        out4_full = 4'h0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        grant_log.delete();
        wr_cyc.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (obs_a_rd !== 2'b00 || obs_wr !== 2'b00) begin
            errors++;
            $display("FAIL reset_strobes rd=%b wr=%b expected 00", obs_a_rd, obs_wr);
        end
        reset = 1'b0;
        step();
        checks++;
        if (obs_din !== 16'h0000 || obs_busy !== 1'b0 || obs_grant !== 1'b0 || obs4_din !== 16'h0000) begin
            errors++;
            $display("FAIL reset_values din=%h busy=%b grant=%0d din4=%h expected 0", obs_din, obs_busy, obs_grant, obs4_din);
        end
    endtask

    task automatic test_single();
        do_reset();
        push(0, 16'h0400, 16'h0800, 16'h0800);
        step();
        checks++;
        if (obs_a_rd !== 2'b01 || obs_b_rd !== 2'b01 || obs_wr !== 2'b00 || obs_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_grant a=%b b=%b wr=%b busy=%b expected 01 01 00 0", obs_a_rd, obs_b_rd, obs_wr, obs_busy);
        end
        step();
        checks++;
        if (obs_wr !== 2'b01 || obs_din !== 16'h0800 || obs_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_write wr=%b din=%h busy=%b expected 01 0800 1", obs_wr, obs_din, obs_busy);
        end
        step();
        checks++;
        if (obs_a_rd !== 2'b00 || obs_busy !== 1'b0 || obs_din !== 16'h0800) begin
            errors++;
            $display("FAIL single_after rd=%b busy=%b din=%h expected 00 0 0800", obs_a_rd, obs_busy, obs_din);
        end
    endtask

    task automatic test_rounding();
        do_reset();
        push(0, 16'hFA00, 16'h0400, 16'hFA00);
        push(0, 16'hFFFF, 16'h0001, 16'h0000);
        push(0, 16'h8000, 16'h8000, 16'h0000);
        push(0, 16'h0401, 16'h0001, 16'h0001);
        push(0, 16'hFBFF, 16'h0001, 16'hFFFF);
        run_drain(40, 1'b0);
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_m(0, 16'($urandom), 16'($urandom));
            push_m(1, 16'($urandom), 16'($urandom));
        end
        run_drain(60, 1'b0);
        checks++;
        if (grant_log.size() != 8) begin
            errors++;
            $display("FAIL rr_count got %0d expected 8", grant_log.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (grant_log[i] != i % 2) begin
                    errors++;
                    $display("FAIL rr_order idx=%0d got %0d expected %0d", i, grant_log[i], i % 2);
                end
            end
        end
        for (int i = 1; i < wr_cyc.size(); i++) begin
            checks++;
            if (wr_cyc[i] - wr_cyc[i-1] != 2) begin
                errors++;
                $display("FAIL rr_spacing idx=%0d got %0d expected 2", i, wr_cyc[i] - wr_cyc[i-1]);
            end
        end
    endtask

`ifdef MULT_SCHED_SKIP_FULL_EN
    task automatic test_stall();
        do_reset();
        push_m(0, 16'h0C00, 16'h0200);
        push_m(1, 16'h0300, 16'h0500);
        push_m(1, 16'hF000, 16'h0100);
        out_full = 2'b01;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (obs_a_rd[0] !== 1'b0 || obs_wr[0] !== 1'b0) begin
                errors++;
                $display("FAIL skip_full cyc=%0d rd0=%b wr0=%b expected 0 0", i, obs_a_rd[0], obs_wr[0]);
            end
        end
        run_drain(40, 1'b0);
        checks++;
        if (grant_log.size() != 3 || grant_log[0] != 1 || grant_log[1] != 1 || grant_log[2] != 0) begin
            errors++;
            $display("FAIL skip_order got size %0d expected grants 1,1,0", grant_log.size());
        end
    endtask
`else
    task automatic test_stall();
        do_reset();
        push_m(0, 16'h0C00, 16'h0200);
        push_m(1, 16'h0300, 16'h0500);
        step();
        checks++;
        if (obs_a_rd !== 2'b01) begin
            errors++;
            $display("FAIL stall_grant rd=%b expected 01", obs_a_rd);
        end
        out_full = 2'b01;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (obs_busy !== 1'b1 || obs_a_rd !== 2'b00 || obs_wr !== 2'b00) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d busy=%b rd=%b wr=%b expected 1 00 00", i, obs_busy, obs_a_rd, obs_wr);
            end
        end
        out_full = 2'b00;
        step();
        checks++;
        if (obs_wr !== 2'b01) begin
            errors++;
            $display("FAIL stall_release wr=%b expected 01", obs_wr);
        end
        step();
        checks++;
        if (obs_a_rd !== 2'b10) begin
            errors++;
            $display("FAIL stall_next rd=%b expected 10", obs_a_rd);
        end
        run_drain(20, 1'b0);
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        push(1, 16'h0C00, 16'h0A00, 16'h1E00);
        step();
        checks++;
        if (obs_a_rd !== 2'b10) begin
            errors++;
            $display("FAIL mid_grant rd=%b expected 10", obs_a_rd);
        end
        reset = 1'b1;
        step();
        checks++;
        if (obs_wr !== 2'b00 || obs_din !== 16'h1E00) begin
            errors++;
            $display("FAIL mid_reset_cycle wr=%b din=%h expected 00 1e00", obs_wr, obs_din);
        end
        eq0.delete();
        eq1.delete();
        reset = 1'b0;
        step();
        checks++;
        if (obs_wr !== 2'b00 || obs_a_rd !== 2'b00 || obs_din !== 16'h0000 ||
            obs_busy !== 1'b0 || obs_grant !== 1'b0) begin
            errors++;
            $display("FAIL mid_after wr=%b rd=%b din=%h busy=%b grant=%0d expected all 0",
                     obs_wr, obs_a_rd, obs_din, obs_busy, obs_grant);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            push_m(0, 16'($urandom), 16'($urandom));
            push_m(1, 16'($urandom), 16'($urandom));
        end
        run_drain(400, 1'b1);
        checks++;
        if (wr_cyc.size() != 20) begin
            errors++;
            $display("FAIL b2b_writes got %0d expected 20", wr_cyc.size());
        end
    endtask

    task automatic test_starvation();
        int g4[$];
        int n;
        logic [15:0] exp2, exp3;
        do_reset();
        a4_dout = {16'hFC00, 16'h0200, 16'h0000, 16'h0000};
        b4_dout = {16'h0C00, 16'h0300, 16'h0000, 16'h0000};
        exp2 = model_deq(16'h0200, 16'h0300);
        exp3 = model_deq(16'hFC00, 16'h0C00);
        a4_empty = 4'b1011;
        b4_empty = 4'b1011;
        step();
        checks++;
        if (obs4_rd !== 4'b0100) begin
            errors++;
            $display("FAIL starve_prime rd=%b expected 0100", obs4_rd);
        end
        a4_empty = 4'b1111;
        b4_empty = 4'b1111;
        step();
        checks++;
        if (obs4_wr !== 4'b0100 || obs4_din !== exp2) begin
            errors++;
            $display("FAIL starve_prime_wr wr=%b din=%h expected 0100 %h", obs4_wr, obs4_din, exp2);
        end
        a4_empty = 4'b0011;
        b4_empty = 4'b0011;
        n = 0;
        while (g4.size() < 4 && n < 20) begin
            step();
            n++;
            for (int c = 0; c < 4; c++) begin
                if (obs4_rd[c]) g4.push_back(c);
            end
            if (obs4_wr != 4'b0000) begin
                checks++;
                if ((obs4_wr == 4'b0100 && obs4_din !== exp2) || (obs4_wr == 4'b1000 && obs4_din !== exp3) ||
                    (obs4_wr != 4'b0100 && obs4_wr != 4'b1000)) begin
                    errors++;
                    $display("FAIL starve_write wr=%b din=%h expected ch2 %h or ch3 %h", obs4_wr, obs4_din, exp2, exp3);
                end
            end
        end
        a4_empty = 4'hF;
        b4_empty = 4'hF;
        checks++;
        if (g4.size() != 4 || g4[0] != 3 || g4[1] != 2 || g4[2] != 3 || g4[3] != 2) begin
            errors++;
            $display("FAIL starve_order got %0d grants expected 3,2,3,2", g4.size());
        end
        step();
        step();
    endtask

    initial begin
        reset     = 1'b1;
        a_dout    = '0;
        b_dout    = '0;
        a_empty   = 2'b11;
        b_empty   = 2'b11;
        out_full  = 2'b00;
        a4_dout   = '0;
        b4_dout   = '0;
        a4_empty  = 4'hF;
        b4_empty  = 4'hF;
        out4_full = 4'h0;
        @(negedge clock);
        test_reset();
        test_single();
        test_rounding();
        test_round_robin();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_starvation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout reached, expected completion");
        $fatal(1);
    end

endmodule
